// File: rtl/spi_master_ctrl.sv
// SPI initiator: serialises 10-bit RAM command words into SS_n/MOSI frames
// and returns the byte shifted back on MISO for read-data commands.
`timescale 1ns/1ps
module spi_master_ctrl #(
  parameter int RD_WAIT = 2,
  parameter int SS_IDLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);
  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_READ, S_GAP} state_t;

  localparam logic [3:0] SEND_LAST = 4'd10;
  localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);
  localparam logic [3:0] READ_LAST = 4'd7;
  localparam logic [3:0] GAP_LAST  = 4'(SS_IDLE - 1);

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic [9:0] shift_reg;
  logic [1:0] opcode;
  logic [6:0] rx_reg;
  logic       ss_n_next, mosi_next, accept, last_sample;

  assign cmd_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign accept      = cmd_valid && cmd_ready;
  assign last_sample = (state == S_READ) && (cnt == READ_LAST);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ss_n_next  = 1'b1;
    mosi_next  = 1'b0;
    case (state)
      S_IDLE: if (cmd_valid) begin
        state_next = S_SEND;
        cnt_next   = '0;
      end
      S_SEND: if (cnt == SEND_LAST) begin
        state_next = (opcode == 2'b11) ? S_WAIT : S_GAP;
        cnt_next   = '0;
      end else cnt_next = cnt + 4'd1;
      S_WAIT: if (cnt == WAIT_LAST) begin
        state_next = S_READ;
        cnt_next   = '0;
      end else cnt_next = cnt + 4'd1;
      S_READ: if (cnt == READ_LAST) begin
        state_next = S_GAP;
        cnt_next   = '0;
      end else cnt_next = cnt + 4'd1;
      S_GAP: if (cnt == GAP_LAST) begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end else cnt_next = cnt + 4'd1;
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
    // SS_n and MOSI are registered, so they follow the state being entered.
    if (state_next inside {S_SEND, S_WAIT, S_READ}) ss_n_next = 1'b0;
    // First bit repeats cmd_data[9] as the path-select bit ahead of the word.
    if (accept) mosi_next = cmd_data[9];
    else if (state == S_SEND && cnt != SEND_LAST) mosi_next = shift_reg[9];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      shift_reg <= '0;
      opcode    <= '0;
      rx_reg    <= '0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      SS_n      <= ss_n_next;
      MOSI      <= mosi_next;
      rsp_valid <= last_sample;
      if (accept) begin
        shift_reg <= cmd_data;
        opcode    <= cmd_data[9:8];
      end else if (state == S_SEND) begin
        shift_reg <= {shift_reg[8:0], 1'b0};
      end
      if (state == S_READ) rx_reg <= {rx_reg[5:0], MISO};
      if (last_sample) rsp_data <= {rx_reg, MISO};
    end
  end
endmodule
